// File: rtl/layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : layer_scheduler
// Description : Registered stage sequencer for the inference pipeline
//               (receive, embed, mix passes, dense, compare, send) with
//               start/abort control, per-stage watchdog, error capture and
//               a run-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_scheduler #(
    parameter int TIMEOUT    = 4096,
    parameter int MIX_PASSES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        recv_valid,
    input  logic        emb_valid,
    input  logic        mix_valid,
    input  logic        dense_valid,
    input  logic        comp_valid,
    input  logic        send_valid,
    output logic        recv_run,
    output logic        emb_run,
    output logic        mix_run,
    output logic        dense_run,
    output logic        comp_run,
    output logic        send_run,
    output logic        stage_start,
    output logic [1:0]  mix_pass,
    output logic [3:0]  state,
    output logic        busy,
    output logic        finish,
    output logic        error,
    output logic [3:0]  err_state,
    output logic [31:0] cycles
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_RECV = 4'd1,
        ST_EMB  = 4'd2,
        ST_MIX1 = 4'd3,
        ST_MIX2 = 4'd4,
        ST_MIX3 = 4'd5,
        ST_DENS = 4'd6,
        ST_COMP = 4'd7,
        ST_SEND = 4'd8,
        ST_FIN  = 4'd9,
        ST_ERR  = 4'd10
    } state_t;

    // Watchdog compare value; TIMEOUT=0 disables the check entirely.
    localparam logic [15:0] c_wdog_last = 16'(TIMEOUT - 1);
    localparam bit          c_wdog_en   = (TIMEOUT != 0);

    state_t      r_state;
    state_t      w_next;
    state_t      w_follow;
    logic        r_stage_start;
    logic [15:0] r_wdog;
    logic [3:0]  r_err_state;
    logic [31:0] r_cycles;
    logic        w_cur_valid;
    logic        w_timed;
    logic        w_timeout;
    logic        w_next_busy;
    logic        w_cur_busy;

    // Select the current stage's done flag, its successor, and whether it is watchdog-timed.
    always_comb begin
        w_cur_valid = 1'b0;
        w_timed     = 1'b0;
        w_follow    = ST_IDLE;
        case (r_state)
            ST_RECV: begin
                w_cur_valid = recv_valid;
                w_follow    = ST_EMB;
            end
            ST_EMB: begin
                w_cur_valid = emb_valid;
                w_timed     = 1'b1;
                w_follow    = ST_MIX1;
            end
            ST_MIX1: begin
                w_cur_valid = mix_valid;
                w_timed     = 1'b1;
                if (MIX_PASSES > 1) w_follow = ST_MIX2;
                else                w_follow = ST_DENS;
            end
            ST_MIX2: begin
                w_cur_valid = mix_valid;
                w_timed     = 1'b1;
                if (MIX_PASSES > 2) w_follow = ST_MIX3;
                else                w_follow = ST_DENS;
            end
            ST_MIX3: begin
                w_cur_valid = mix_valid;
                w_timed     = 1'b1;
                w_follow    = ST_DENS;
            end
            ST_DENS: begin
                w_cur_valid = dense_valid;
                w_timed     = 1'b1;
                w_follow    = ST_COMP;
            end
            ST_COMP: begin
                w_cur_valid = comp_valid;
                w_timed     = 1'b1;
                w_follow    = ST_SEND;
            end
            ST_SEND: begin
                w_cur_valid = send_valid;
                w_follow    = ST_FIN;
            end
            default: ;
        endcase
    end

    // A stage's own valid in the limit cycle beats the watchdog.
    assign w_timeout = c_wdog_en && w_timed && !w_cur_valid && (r_wdog == c_wdog_last);

    // Next-state decision; abort overrides everything else.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_FIN: begin
                if (start) w_next = ST_RECV;
            end
            ST_RECV, ST_EMB, ST_MIX1, ST_MIX2, ST_MIX3,
            ST_DENS, ST_COMP, ST_SEND: begin
                if (w_cur_valid)    w_next = w_follow;
                else if (w_timeout) w_next = ST_ERR;
            end
            ST_ERR:  w_next = ST_ERR;
            default: w_next = ST_IDLE;
        endcase
        if (abort) w_next = ST_IDLE;
    end

    assign w_next_busy = (w_next >= ST_RECV) && (w_next <= ST_SEND);
    assign w_cur_busy  = (r_state >= ST_RECV) && (r_state <= ST_SEND);

    // State register, stage-entry pulse and per-stage watchdog counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_stage_start <= 1'b0;
            r_wdog        <= '0;
        end else begin
            r_state       <= w_next;
            r_stage_start <= w_next_busy && (w_next != r_state);
            if (w_next != r_state) r_wdog <= '0;
            else if (w_timed)      r_wdog <= r_wdog + 16'd1;
        end
    end

    // Remember which stage stalled; abort wipes the record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_state <= 4'd0;
        end else if (abort) begin
            r_err_state <= 4'd0;
        end else if (w_timeout && !w_cur_valid) begin
            r_err_state <= r_state;
        end
    end

    // Run-length counter: restarts on an accepted start, saturates, holds outside a run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycles <= 32'd0;
        end else if (!abort && start && (r_state == ST_IDLE || r_state == ST_FIN)) begin
            r_cycles <= 32'd0;
        end else if (w_cur_busy && (r_cycles != 32'hFFFF_FFFF)) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign recv_run    = (r_state == ST_RECV);
    assign emb_run     = (r_state == ST_EMB);
    assign mix_run     = (r_state == ST_MIX1) || (r_state == ST_MIX2) || (r_state == ST_MIX3);
    assign dense_run   = (r_state == ST_DENS);
    assign comp_run    = (r_state == ST_COMP);
    assign send_run    = (r_state == ST_SEND);
    assign stage_start = r_stage_start;
    assign mix_pass    = (r_state == ST_MIX2) ? 2'd1 :
                         (r_state == ST_MIX3) ? 2'd2 : 2'd0;
    assign state       = r_state;
    assign busy        = w_cur_busy;
    assign finish      = (r_state == ST_FIN);
    assign error       = (r_state == ST_ERR);
    assign err_state   = r_err_state;
    assign cycles      = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_layer_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_layer_scheduler
// Description : Directed self-checking bench for layer_scheduler. Instance A
//               uses TIMEOUT=16, MIX_PASSES=3; instance B uses MIX_PASSES=1.
//               Both share stimulus; each scenario checks one instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_scheduler;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic [5:0] valid_v = 6'd0;   // {send,comp,dense,mix,emb,recv}

    wire [5:0]  runs_a, runs_b;
    wire        ss_a, ss_b, busy_a, busy_b, fin_a, fin_b, err_a, err_b;
    wire [1:0]  mp_a, mp_b;
    wire [3:0]  st_a, st_b, es_a, es_b;
    wire [31:0] cyc_a, cyc_b;

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         sel_b    = 1'b0;
    bit         count_en = 1'b0;
    int         ss_cnt   = 0;
    logic [3:0] seen_st[$];
    logic [1:0] seen_mp[$];

    layer_scheduler #(.TIMEOUT(16), .MIX_PASSES(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .recv_valid(valid_v[0]), .emb_valid(valid_v[1]), .mix_valid(valid_v[2]),
        .dense_valid(valid_v[3]), .comp_valid(valid_v[4]), .send_valid(valid_v[5]),
        .recv_run(runs_a[0]), .emb_run(runs_a[1]), .mix_run(runs_a[2]),
        .dense_run(runs_a[3]), .comp_run(runs_a[4]), .send_run(runs_a[5]),
        .stage_start(ss_a), .mix_pass(mp_a), .state(st_a), .busy(busy_a),
        .finish(fin_a), .error(err_a), .err_state(es_a), .cycles(cyc_a)
    );

    layer_scheduler #(.TIMEOUT(4096), .MIX_PASSES(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .recv_valid(valid_v[0]), .emb_valid(valid_v[1]), .mix_valid(valid_v[2]),
        .dense_valid(valid_v[3]), .comp_valid(valid_v[4]), .send_valid(valid_v[5]),
        .recv_run(runs_b[0]), .emb_run(runs_b[1]), .mix_run(runs_b[2]),
        .dense_run(runs_b[3]), .comp_run(runs_b[4]), .send_run(runs_b[5]),
        .stage_start(ss_b), .mix_pass(mp_b), .state(st_b), .busy(busy_b),
        .finish(fin_b), .error(err_b), .err_state(es_b), .cycles(cyc_b)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0]  cur_st();   return sel_b ? st_b   : st_a;   endfunction
    function automatic logic        cur_ss();   return sel_b ? ss_b   : ss_a;   endfunction
    function automatic logic [1:0]  cur_mp();   return sel_b ? mp_b   : mp_a;   endfunction
    function automatic logic [5:0]  cur_runs(); return sel_b ? runs_b : runs_a; endfunction
    function automatic logic        cur_fin();  return sel_b ? fin_b  : fin_a;  endfunction
    function automatic logic        cur_busy(); return sel_b ? busy_b : busy_a; endfunction
    function automatic logic [31:0] cur_cyc();  return sel_b ? cyc_b  : cyc_a;  endfunction

    function automatic logic [5:0] stage_bit(input logic [3:0] s);
        case (s)
            4'd1:             return 6'b000001;
            4'd2:             return 6'b000010;
            4'd3, 4'd4, 4'd5: return 6'b000100;
            4'd6:             return 6'b001000;
            4'd7:             return 6'b010000;
            4'd8:             return 6'b100000;
            default:          return 6'b000000;
        endcase
    endfunction

    // One clock; outputs are observed 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (count_en && cur_ss()) ss_cnt++;
    endtask

    // Walk nst stages: hold each for dly cycles after entry, then pulse its valid.
    task automatic walk(input int nst, input int dly);
        for (int s = 0; s < nst; s++) begin
            seen_st.push_back(cur_st());
            seen_mp.push_back(cur_mp());
            repeat (dly) step();
            valid_v = stage_bit(cur_st());
            step();
            valid_v = 6'd0;
        end
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (st_a !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", st_a); end
        n_checks++; if (runs_a !== 6'd0 || ss_a !== 1'b0) begin n_fail++; $display("FAIL reset_runs got %b/%b want 0", runs_a, ss_a); end
        n_checks++; if ({busy_a, fin_a, err_a, mp_a, es_a} !== 9'd0) begin n_fail++; $display("FAIL reset_flags got %b want 0", {busy_a, fin_a, err_a, mp_a, es_a}); end
        n_checks++; if (cyc_a !== 32'd0) begin n_fail++; $display("FAIL reset_cycles got %0d want 0", cyc_a); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++; if (st_a !== 4'd0) begin n_fail++; $display("FAIL idle_after_reset got %0d want 0", st_a); end
    endtask

    task automatic test_nominal();
        logic [3:0] exp_st[8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        logic [1:0] exp_mp[8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
        sel_b = 1'b0; seen_st.delete(); seen_mp.delete(); ss_cnt = 0; count_en = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        n_checks++; if (st_a !== 4'd1 || runs_a !== 6'b000001 || ss_a !== 1'b1) begin n_fail++; $display("FAIL nom_recv_entry got st=%0d runs=%b ss=%b want 1/000001/1", st_a, runs_a, ss_a); end
        n_checks++; if (cyc_a !== 32'd0 || busy_a !== 1'b1) begin n_fail++; $display("FAIL nom_recv_cycles got %0d busy=%b want 0/1", cyc_a, busy_a); end
        walk(8, 3);
        count_en = 1'b0;
        n_checks++; if (seen_st.size() != 8) begin n_fail++; $display("FAIL nom_seq_len got %0d want 8", seen_st.size()); end
        for (int i = 0; i < 8 && i < seen_st.size(); i++) begin
            n_checks++; if (seen_st[i] !== exp_st[i]) begin n_fail++; $display("FAIL nom_seq[%0d] got %0d want %0d", i, seen_st[i], exp_st[i]); end
            n_checks++; if (seen_mp[i] !== exp_mp[i]) begin n_fail++; $display("FAIL nom_mix_pass[%0d] got %0d want %0d", i, seen_mp[i], exp_mp[i]); end
        end
        n_checks++; if (ss_cnt != 8) begin n_fail++; $display("FAIL nom_stage_start_count got %0d want 8", ss_cnt); end
        n_checks++; if (st_a !== 4'd9 || fin_a !== 1'b1 || busy_a !== 1'b0) begin n_fail++; $display("FAIL nom_fin got st=%0d fin=%b busy=%b want 9/1/0", st_a, fin_a, busy_a); end
        n_checks++; if (cyc_a !== 32'd32) begin n_fail++; $display("FAIL nom_cycles got %0d want 32", cyc_a); end
        n_checks++; if (runs_a !== 6'd0) begin n_fail++; $display("FAIL nom_runs_fin got %b want 0", runs_a); end
    endtask

    task automatic test_stray();
        sel_b = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        walk(3, 3);
        n_checks++; if (st_a !== 4'd4) begin n_fail++; $display("FAIL stray_mix2_entry got %0d want 4", st_a); end
        valid_v = 6'b010000; step(); valid_v = 6'd0;
        n_checks++; if (st_a !== 4'd4 || runs_a !== 6'b000100 || mp_a !== 2'd1) begin n_fail++; $display("FAIL stray_comp_in_mix2 got st=%0d runs=%b mp=%0d want 4/000100/1", st_a, runs_a, mp_a); end
        valid_v = 6'b000100; step(); valid_v = 6'd0;
        walk(3, 3);
        n_checks++; if (st_a !== 4'd8) begin n_fail++; $display("FAIL stray_send_entry got %0d want 8", st_a); end
        start = 1'b1; step(); start = 1'b0;
        n_checks++; if (st_a !== 4'd8 || fin_a !== 1'b0) begin n_fail++; $display("FAIL start_in_send got st=%0d fin=%b want 8/0", st_a, fin_a); end
        abort = 1'b1; valid_v = 6'b100000; step(); abort = 1'b0; valid_v = 6'd0;
        n_checks++; if (st_a !== 4'd0 || fin_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL abort_vs_send got st=%0d fin=%b want 0/0", st_a, fin_a); end
        n_checks++; if (cyc_a !== 32'd28) begin n_fail++; $display("FAIL abort_keeps_cycles got %0d want 28", cyc_a); end
    endtask

    task automatic test_timeout();
        sel_b = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        valid_v = 6'b000001; step(); valid_v = 6'd0;
        n_checks++; if (st_a !== 4'd2 || ss_a !== 1'b1) begin n_fail++; $display("FAIL to_emb_entry got st=%0d ss=%b want 2/1", st_a, ss_a); end
        repeat (15) step();
        n_checks++; if (st_a !== 4'd2 || err_a !== 1'b0) begin n_fail++; $display("FAIL to_before_limit got st=%0d err=%b want 2/0", st_a, err_a); end
        step();
        n_checks++; if (err_a !== 1'b1 || st_a !== 4'd10) begin n_fail++; $display("FAIL to_error got err=%b st=%0d want 1/10", err_a, st_a); end
        n_checks++; if (es_a !== 4'd2) begin n_fail++; $display("FAIL to_err_state got %0d want 2", es_a); end
        n_checks++; if (runs_a !== 6'd0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL to_runs_drop got %b busy=%b want 0/0", runs_a, busy_a); end
        start = 1'b1; step(); start = 1'b0;
        n_checks++; if (st_a !== 4'd10) begin n_fail++; $display("FAIL start_in_err got %0d want 10", st_a); end
        abort = 1'b1; step(); abort = 1'b0;
        n_checks++; if (st_a !== 4'd0 || err_a !== 1'b0 || es_a !== 4'd0) begin n_fail++; $display("FAIL to_abort got st=%0d err=%b es=%0d want 0/0/0", st_a, err_a, es_a); end
    endtask

    task automatic test_wd_boundary();
        sel_b = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        walk(5, 3);
        repeat (15) step();
        n_checks++; if (st_a !== 4'd6 || err_a !== 1'b0) begin n_fail++; $display("FAIL wd_dens16 got st=%0d err=%b want 6/0", st_a, err_a); end
        valid_v = 6'b001000; step(); valid_v = 6'd0;
        n_checks++; if (st_a !== 4'd7 || err_a !== 1'b0 || ss_a !== 1'b1) begin n_fail++; $display("FAIL wd_valid_wins got st=%0d err=%b ss=%b want 7/0/1", st_a, err_a, ss_a); end
        walk(2, 3);
        n_checks++; if (fin_a !== 1'b1) begin n_fail++; $display("FAIL wd_fin got %b want 1", fin_a); end
    endtask

    task automatic test_mix1();
        logic [3:0] exp_st[6] = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8};
        abort = 1'b1; step(); abort = 1'b0;
        sel_b = 1'b1; seen_st.delete(); seen_mp.delete();
        start = 1'b1; step(); start = 1'b0;
        walk(6, 3);
        n_checks++; if (seen_st.size() != 6) begin n_fail++; $display("FAIL mix1_seq_len got %0d want 6", seen_st.size()); end
        for (int i = 0; i < 6 && i < seen_st.size(); i++) begin
            n_checks++; if (seen_st[i] !== exp_st[i]) begin n_fail++; $display("FAIL mix1_seq[%0d] got %0d want %0d", i, seen_st[i], exp_st[i]); end
        end
        n_checks++; if (cur_fin() !== 1'b1 || cur_cyc() !== 32'd24) begin n_fail++; $display("FAIL mix1_fin got fin=%b cyc=%0d want 1/24", cur_fin(), cur_cyc()); end
        start = 1'b1; step(); start = 1'b0;
        n_checks++; if (cur_st() !== 4'd1 || cur_cyc() !== 32'd0) begin n_fail++; $display("FAIL mix1_restart got st=%0d cyc=%0d want 1/0", cur_st(), cur_cyc()); end
        walk(6, 1);
        n_checks++; if (cur_fin() !== 1'b1 || cur_cyc() !== 32'd12) begin n_fail++; $display("FAIL mix1_rerun got fin=%b cyc=%0d want 1/12", cur_fin(), cur_cyc()); end
        sel_b = 1'b0;
    endtask

    task automatic test_async_reset();
        sel_b = 1'b0;
        abort = 1'b1; step(); abort = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        walk(5, 3);
        step(); step();
        n_checks++; if (st_a !== 4'd6) begin n_fail++; $display("FAIL ar_in_dens got %0d want 6", st_a); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (st_a !== 4'd0 || runs_a !== 6'd0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL ar_immediate got st=%0d runs=%b busy=%b want 0/0/0", st_a, runs_a, busy_a); end
        n_checks++; if (cyc_a !== 32'd0) begin n_fail++; $display("FAIL ar_cycles got %0d want 0", cyc_a); end
        #9 rst_n = 1'b1;
        step();
        n_checks++; if (st_a !== 4'd0) begin n_fail++; $display("FAIL ar_stays_idle got %0d want 0", st_a); end
        ss_cnt = 0; count_en = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        walk(8, 3);
        count_en = 1'b0;
        n_checks++; if (fin_a !== 1'b1 || cyc_a !== 32'd32 || ss_cnt != 8) begin n_fail++; $display("FAIL ar_fresh_run got fin=%b cyc=%0d ss=%0d want 1/32/8", fin_a, cyc_a, ss_cnt); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stray();
        test_timeout();
        test_wd_boundary();
        test_mix1();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
